// File: rtl/sram_mgmt_arbiter.sv
// Merges a management req/ack port onto eight SRAM macros behind the cache; the cache always wins.
// Latency (no contention) write 3 / read 4 cycles. Management stalls while any cache csb is low. Optional SRAM_MGMT_STARVE_EN aborts long waits.
module sram_mgmt_arbiter #(
  parameter int NBANK        = 8,
  parameter int AW           = 9,
  parameter int STARVE_LIMIT = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NBANK-1:0]      c_csb,
  input  logic                  c_web,
  input  logic [AW-1:0]         c_addr,
  input  logic [3:0]            c_wmask,
  input  logic [31:0]           c_din,
  input  logic                  m_req,
  input  logic                  m_we,
  input  logic [AW+$clog2(NBANK)-1:0] m_addr,
  input  logic [3:0]            m_wmask,
  input  logic [31:0]           m_wdata,
  output logic                  m_ack,
  output logic [31:0]           m_rdata,
  output logic                  m_err,
  output logic [NBANK-1:0]      ram_csb,
  output logic                  ram_web,
  output logic [AW-1:0]         ram_addr,
  output logic [3:0]            ram_wmask,
  output logic [31:0]           ram_din,
  input  logic [NBANK*32-1:0]   ram_dout
);

  localparam int BW = $clog2(NBANK);

  if (STARVE_LIMIT < 0 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("STARVE_LIMIT must fit the 8-bit wait counter");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_ACK} state_t;

  state_t          state_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [BW-1:0]   bank_q;
  logic [3:0]      wmask_q;
  logic [31:0]     wdata_q;
  logic            ack_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic            cache_busy;
  logic            grant;

`ifdef SRAM_MGMT_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0]      cnt_q;
`endif

  assign cache_busy = ~&c_csb;
  assign grant      = (state_q == S_WAIT) && !cache_busy;

  // Macro pins follow the cache except in the single management grant cycle.
  always_comb begin
    ram_csb   = c_csb;
    ram_web   = c_web;
    ram_addr  = c_addr;
    ram_wmask = c_wmask;
    ram_din   = c_din;
    if (grant) begin
      ram_csb   = ~(NBANK'(1) << bank_q);
      ram_web   = ~we_q;
      ram_addr  = addr_q;
      ram_wmask = wmask_q;
      ram_din   = wdata_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      bank_q  <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef SRAM_MGMT_STARVE_EN
      cnt_q   <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (m_req) begin
            we_q    <= m_we;
            addr_q  <= m_addr[AW-1:0];
            bank_q  <= m_addr[AW+BW-1:AW];
            wmask_q <= m_wmask;
            wdata_q <= m_wdata;
            state_q <= S_WAIT;
`ifdef SRAM_MGMT_STARVE_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (!cache_busy) begin
            state_q <= we_q ? S_ACK : S_CAPT;
            ack_q   <= we_q;
          end
`ifdef SRAM_MGMT_STARVE_EN
          // A grant in the limit cycle wins; the abort only fires while still blocked.
          else if (cnt_q == LIMIT) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        S_CAPT: begin
          rdata_q <= ram_dout[{bank_q, 5'd0} +: 32];
          state_q <= S_ACK;
          ack_q   <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_ack   = ack_q;
  assign m_rdata = rdata_q;
`ifdef SRAM_MGMT_STARVE_EN
  assign m_err   = err_q;
`else
  assign m_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_mgmt_arbiter.sv
// Bench for sram_mgmt_arbiter: SRAM macro model, reference memory and per-cycle checks of pins/ack/data.
module tb_sram_mgmt_arbiter;
  localparam int NB = 8;
  localparam int AW = 9;
`ifdef SRAM_MGMT_STARVE_EN
  localparam int LIM    = 4;
  localparam bit STARVE = 1'b1;
`else
  localparam int LIM    = 255;
  localparam bit STARVE = 1'b0;
`endif

  logic          clock;
  logic          reset_n;
  logic [NB-1:0] c_csb;
  logic          c_web;
  logic [AW-1:0] c_addr;
  logic [3:0]    c_wmask;
  logic [31:0]   c_din;
  logic          m_req;
  logic          m_we;
  logic [11:0]   m_addr;
  logic [3:0]    m_wmask;
  logic [31:0]   m_wdata;
  logic          m_ack;
  logic [31:0]   m_rdata;
  logic          m_err;
  logic [NB-1:0] ram_csb;
  logic          ram_web;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wmask;
  logic [31:0]   ram_din;
  logic [NB*32-1:0] ram_dout;

  int checks;
  int failures;

  sram_mgmt_arbiter #(.NBANK(NB), .AW(AW), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset_n(reset_n),
    .c_csb(c_csb), .c_web(c_web), .c_addr(c_addr), .c_wmask(c_wmask), .c_din(c_din),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wmask(m_wmask), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .ram_csb(ram_csb), .ram_web(ram_web), .ram_addr(ram_addr), .ram_wmask(ram_wmask),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read macro model: data appears the cycle after chip select.
  bit [31:0] mem [NB*512];
  bit [31:0] dout [NB];
  always @(posedge clock) begin
    for (int k = 0; k < NB; k++) begin
      if (!ram_csb[k]) begin
        if (!ram_web) begin
          bit [31:0] w;
          w = mem[k*512 + int'(ram_addr)];
          for (int b = 0; b < 4; b++)
            if (ram_wmask[b]) w[8*b +: 8] = ram_din[8*b +: 8];
          mem[k*512 + int'(ram_addr)] <= w;
        end else begin
          dout[k] <= mem[k*512 + int'(ram_addr)];
        end
      end
    end
  end
  always_comb begin
    ram_dout = '0;
    for (int k = 0; k < NB; k++) ram_dout[32*k +: 32] = dout[k];
  end

  bit [31:0]   refm [NB*512];
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cache(input logic [7:0] csb);
    c_csb   = csb;
    c_web   = 1'b1;
    c_addr  = AW'($urandom);
    c_wmask = 4'($urandom);
    c_din   = $urandom;
  endtask

  function automatic logic [7:0] busy_csb();
    logic [7:0] v;
    v = 8'($urandom);
    if (v == 8'hFF) v = 8'hFE;
    return v;
  endfunction

  function automatic logic [63:0] pins_obs();
    return 64'({ram_csb, ram_web, ram_addr, ram_wmask, ram_din});
  endfunction

  function automatic logic [63:0] pins_cache();
    return 64'({c_csb, c_web, c_addr, c_wmask, c_din});
  endfunction

  // One management transaction; nb busy cache cycles follow the request cycle.
  task automatic run_txn(input bit we, input logic [11:0] a, input logic [3:0] wm,
                         input logic [31:0] wd, input int nb, input bit rnd);
    logic [7:0] pat[$];
    int g, ack_cyc, len;
    bit abort;
    logic [63:0] mg;
    len = nb + 6;
    pat.push_back(8'($urandom));
    for (int j = 1; j <= nb; j++) pat.push_back(busy_csb());
    pat.push_back(8'hFF);
    for (int j = nb + 2; j < len; j++) pat.push_back(rnd ? 8'($urandom) : 8'hFF);
    g = len;
    for (int j = len - 1; j >= 1; j--) if (pat[j] == 8'hFF) g = j;
    abort   = STARVE && (g > LIM + 1);
    ack_cyc = abort ? LIM + 2 : g + (we ? 1 : 2);
    mg = 64'({~(8'b1 << a[11:9]), ~we, a[8:0], wm, wd});
    if (!we && !abort) exp_rdata = refm[int'(a)];
    for (int j = 0; j <= ack_cyc + 1; j++) begin
      @(negedge clock);
      drive_cache(pat[j]);
      m_req   = (j < ack_cyc);
      m_we    = we;
      m_addr  = a;
      m_wmask = wm;
      m_wdata = wd;
      #1;
      chk("pins", pins_obs(), (!abort && j == g) ? mg : pins_cache());
      chk("ack", 64'(m_ack), 64'(j == ack_cyc));
      chk("err", 64'(m_err), 64'(abort && j == ack_cyc));
      if (j == ack_cyc) chk("rdata", 64'(m_rdata), 64'(exp_rdata));
    end
    if (we && !abort)
      for (int b = 0; b < 4; b++)
        if (wm[b]) refm[int'(a)][8*b +: 8] = wd[8*b +: 8];
    m_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    exp_rdata = '0;
    reset_n = 1'b0;
    m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wmask = '0; m_wdata = '0;
    drive_cache(8'hF0);
    @(negedge clock);
    #1;
    chk("rst_ack", 64'(m_ack), 64'(0));
    chk("rst_err", 64'(m_err), 64'(0));
    chk("rst_rdata", 64'(m_rdata), 64'(0));
    chk("rst_pins", pins_obs(), pins_cache());
    @(negedge clock);
    reset_n = 1'b1;

    run_txn(1'b1, 12'h5A3, 4'hF, 32'hDEADBEEF, 0, 1'b0);
    run_txn(1'b0, 12'h5A3, 4'hF, 32'h0, 0, 1'b0);
    run_txn(1'b1, 12'h5A3, 4'h5, 32'h11223344, 0, 1'b0);
    run_txn(1'b0, 12'h5A3, 4'h0, 32'h0, 10 < LIM ? 10 : LIM, 1'b1);
    run_txn(1'b1, 12'hFFF, 4'hF, 32'hCAFEF00D, 2, 1'b1);
    run_txn(1'b0, 12'hFFF, 4'hF, 32'h0, 1, 1'b1);
    run_txn(1'b1, 12'h000, 4'hF, 32'h0BAD0BAD, 0, 1'b1);
    run_txn(1'b0, 12'h000, 4'hF, 32'h0, 0, 1'b1);

    // Reset while the request waits behind the cache.
    @(negedge clock);
    m_req = 1'b1; m_we = 1'b0; m_addr = 12'hFFF;
    drive_cache(8'hFE);
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      drive_cache(busy_csb());
    end
    reset_n = 1'b0;
    m_req = 1'b0;
    #1;
    chk("rstw_pins", pins_obs(), pins_cache());
    chk("rstw_ack", 64'(m_ack), 64'(0));
    @(negedge clock);
    drive_cache(8'hFF);
    #1;
    chk("rstw_idle_pins", pins_obs(), pins_cache());
    reset_n = 1'b1;
    exp_rdata = '0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      drive_cache(8'hFF);
      #1;
      chk("post_rst_pins", pins_obs(), pins_cache());
      chk("post_rst_ack", 64'(m_ack), 64'(0));
      chk("post_rst_rdata", 64'(m_rdata), 64'(0));
    end
    run_txn(1'b0, 12'hFFF, 4'hF, 32'h0, 0, 1'b0);

`ifdef SRAM_MGMT_STARVE_EN
    run_txn(1'b0, 12'h5A3, 4'hF, 32'h0, LIM + 3, 1'b1);
    run_txn(1'b1, 12'h123, 4'hF, 32'h55AA55AA, LIM + 1, 1'b1);
    run_txn(1'b1, 12'h123, 4'hF, 32'h12345678, LIM, 1'b1);
    run_txn(1'b0, 12'h123, 4'hF, 32'h0, 0, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 12'($urandom), 4'($urandom), $urandom,
              int'($urandom_range(0, STARVE ? LIM + 3 : 6)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
